// File: rtl/uart_arb_pkg.sv
// Shared types and sizes for the UART message arbiter: state encoding,
// payload/length widths and the per-message byte limit.
package uart_arb_pkg;

    localparam int UART_MAXB = 10;
    localparam int UART_PLW  = 80;
    localparam int UART_LENW = 4;
    localparam int UART_IDW  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAITRDY,
        S_ISSUE,
        S_GUARD
    } arb_state_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: picks the first set request after the
// pointer position, wrapping around, and returns it one-hot and as an index.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    logic [IW-1:0] w_lo_idx;
    logic [IW-1:0] w_hi_idx;
    logic          w_lo_vld;
    logic          w_hi_vld;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        w_lo_idx = '0;
        w_hi_idx = '0;
        w_lo_vld = 1'b0;
        w_hi_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                if (IW'(i) > i_ptr) begin
                    w_hi_idx = IW'(i);
                    w_hi_vld = 1'b1;
                end else begin
                    w_lo_idx = IW'(i);
                    w_lo_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_vld = w_hi_vld | w_lo_vld;
        o_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
        o_gnt = '0;
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = o_vld && (IW'(i) == o_idx);
        end
    end

endmodule

// File: rtl/uart_msg_arb.sv
// Round-robin sharing of one UART byte transmitter among NREQ message sources.
// Define UART_ARB_CHKSUM_EN to append an XOR checksum byte to every message.
//
// state   | meaning
// IDLE    | no message; arbitrate among pending requests
// LOAD    | latch winner's payload/length, ack it, advance RR pointer
// WAITRDY | wait for transmitter ready
// ISSUE   | one-cycle byte write strobe
// GUARD   | fixed settle time after each write, then next byte or done
module uart_msg_arb
    import uart_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int GUARD = 5,
    parameter int MAXB  = UART_MAXB
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NREQ-1:0]             i_req,
    input  logic [NREQ*UART_PLW-1:0]    i_req_data,
    input  logic [NREQ*UART_LENW-1:0]   i_req_len,
    output logic [NREQ-1:0]             o_req_ack,
    output logic [NREQ-1:0]             o_msg_done,
    output logic [UART_IDW-1:0]         o_grant_id,
    output logic                        o_busy,
    output logic [7:0]                  o_uart_data,
    output logic                        o_uart_wr,
    input  logic                        i_tx_rdy
);

    localparam int GCW = (GUARD > 1) ? $clog2(GUARD) : 1;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [UART_IDW-1:0]  r_grant;
    logic [NREQ-1:0]      r_grant_oh;
    logic [UART_IDW-1:0]  r_ptr;
    logic [UART_PLW-1:0]  r_payload;
    logic [UART_LENW-1:0] r_len;
    logic [UART_LENW-1:0] r_k;
    logic [GCW-1:0]       r_gcnt;
    logic [7:0]           r_uart_data;

    logic [NREQ-1:0]      w_arb_gnt;
    logic [UART_IDW-1:0]  w_arb_idx;
    logic                 w_arb_vld;
    logic [UART_PLW-1:0]  w_payload_in;
    logic [UART_LENW-1:0] w_len_raw;
    logic [UART_LENW-1:0] w_len_in;
    logic [UART_LENW-1:0] w_sel;
    logic [UART_LENW-1:0] w_last_k;
    logic [7:0]           w_byte;
    logic                 w_last;

`ifdef UART_ARB_CHKSUM_EN
    logic [7:0]           r_xor;
`endif

    rr_arb #(
        .N  (NREQ),
        .IW (UART_IDW)
    ) u_rr_arb (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_vld (w_arb_vld)
    );

    always_comb begin
        w_payload_in = '0;
        w_len_raw    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant_oh[i]) begin
                w_payload_in = i_req_data[i*UART_PLW +: UART_PLW];
                w_len_raw    = i_req_len[i*UART_LENW +: UART_LENW];
            end
        end
        w_len_in = (w_len_raw > UART_LENW'(MAXB)) ? UART_LENW'(MAXB) : w_len_raw;
    end

    // Bytes are right-aligned, so byte k of a len-byte message sits at len-1-k.
    always_comb begin
        w_sel  = r_len - r_k - 4'd1;
        w_byte = '0;
        for (int j = 0; j < UART_PLW / 8; j++) begin
            if (w_sel == UART_LENW'(j)) begin
                w_byte = r_payload[j*8 +: 8];
            end
        end
`ifdef UART_ARB_CHKSUM_EN
        if (r_k == r_len) begin
            w_byte = r_xor;
        end
        w_last_k = r_len;
`else
        w_last_k = r_len - 4'd1;
`endif
        w_last = (r_k == w_last_k);
    end

    always_comb begin
        w_state_nxt = r_state;
        o_req_ack   = '0;
        o_msg_done  = '0;
        o_uart_wr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb_vld) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                o_req_ack = r_grant_oh;
`ifdef UART_ARB_CHKSUM_EN
                w_state_nxt = S_WAITRDY;
`else
                if (w_len_in == '0) begin
                    o_msg_done  = r_grant_oh;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAITRDY;
                end
`endif
            end
            S_WAITRDY: begin
                if (i_tx_rdy) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_uart_wr   = 1'b1;
                w_state_nxt = S_GUARD;
            end
            S_GUARD: begin
                if (r_gcnt == '0) begin
                    if (w_last) begin
                        o_msg_done  = r_grant_oh;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAITRDY;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_grant_oh  <= '0;
            r_ptr       <= UART_IDW'(NREQ - 1);
            r_payload   <= '0;
            r_len       <= '0;
            r_k         <= '0;
            r_gcnt      <= '0;
            r_uart_data <= '0;
`ifdef UART_ARB_CHKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_arb_vld) begin
                        r_grant    <= w_arb_idx;
                        r_grant_oh <= w_arb_gnt;
                    end
                end
                S_LOAD: begin
                    r_payload <= w_payload_in;
                    r_len     <= w_len_in;
                    r_k       <= '0;
                    r_ptr     <= r_grant;
`ifdef UART_ARB_CHKSUM_EN
                    r_xor     <= '0;
`endif
                end
                S_WAITRDY: begin
                    if (i_tx_rdy) begin
                        r_uart_data <= w_byte;
                    end
                end
                S_ISSUE: begin
                    r_gcnt <= GCW'(GUARD - 1);
`ifdef UART_ARB_CHKSUM_EN
                    r_xor  <= r_xor ^ r_uart_data;
`endif
                end
                S_GUARD: begin
                    if (r_gcnt != '0) begin
                        r_gcnt <= r_gcnt - 1'b1;
                    end else if (!w_last) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_grant_id  = r_grant;
    assign o_uart_data = r_uart_data;

endmodule

// File: tb/tb_uart_msg_arb.sv
// Directed bench for uart_msg_arb (default build, no checksum byte): logs
// writes/acks/dones per cycle and checks them against hand-computed values.
module tb_uart_msg_arb;

    localparam int NREQ  = 4;
    localparam int GUARD = 5;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic [NREQ-1:0]     i_req = '0;
    logic [NREQ*80-1:0]  i_req_data = '0;
    logic [NREQ*4-1:0]   i_req_len = '0;
    logic                i_tx_rdy = 1'b1;
    logic [NREQ-1:0]     o_req_ack;
    logic [NREQ-1:0]     o_msg_done;
    logic [2:0]          o_grant_id;
    logic                o_busy;
    logic [7:0]          o_uart_data;
    logic                o_uart_wr;

    uart_msg_arb #(
        .NREQ  (NREQ),
        .GUARD (GUARD),
        .MAXB  (10)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_req_data (i_req_data),
        .i_req_len  (i_req_len),
        .o_req_ack  (o_req_ack),
        .o_msg_done (o_msg_done),
        .o_grant_id (o_grant_id),
        .o_busy     (o_busy),
        .o_uart_data(o_uart_data),
        .o_uart_wr  (o_uart_wr),
        .i_tx_rdy   (i_tx_rdy)
    );

    always #5 i_clk = ~i_clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit auto_clr = 1'b1;

    logic [7:0] wr_byte_q[$];
    int         wr_cyc_q[$];
    logic [3:0] ack_q[$];
    logic [2:0] ack_gid_q[$];
    int         ack_cyc_q[$];
    logic [3:0] done_q[$];
    int         done_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_uart_wr) begin
            wr_byte_q.push_back(o_uart_data);
            wr_cyc_q.push_back(cyc);
        end
        if (o_req_ack != '0) begin
            ack_q.push_back(o_req_ack);
            ack_gid_q.push_back(o_grant_id);
            ack_cyc_q.push_back(cyc);
            if (auto_clr) i_req = i_req & ~o_req_ack;
        end
        if (o_msg_done != '0) begin
            done_q.push_back(o_msg_done);
            done_cyc_q.push_back(cyc);
        end
    endtask

    task automatic clear_logs();
        wr_byte_q.delete();
        wr_cyc_q.delete();
        ack_q.delete();
        ack_gid_q.delete();
        ack_cyc_q.delete();
        done_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic outs_idle(input string tag);
        chk({tag, "_wr"},    32'(o_uart_wr),   32'h0);
        chk({tag, "_data"},  32'(o_uart_data), 32'h0);
        chk({tag, "_ack"},   32'(o_req_ack),   32'h0);
        chk({tag, "_done"},  32'(o_msg_done),  32'h0);
        chk({tag, "_busy"},  32'(o_busy),      32'h0);
        chk({tag, "_gid"},   32'(o_grant_id),  32'h0);
    endtask

    task automatic do_reset(input string tag);
        i_rst    = 1'b1;
        i_req    = '0;
        i_tx_rdy = 1'b1;
        auto_clr = 1'b1;
        step();
        step();
        outs_idle(tag);
        i_rst = 1'b0;
        clear_logs();
    endtask

    task automatic set_req(input int id, input logic [79:0] data, input logic [3:0] len);
        i_req_data[id*80 +: 80] = data;
        i_req_len[id*4 +: 4]    = len;
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        for (int c = 0; c < budget && done_q.size() < n; c++) step();
        chk({tag, "_ndone"}, 32'(done_q.size()), 32'(n));
    endtask

    task automatic wait_acks(input string tag, input int n, input int budget);
        for (int c = 0; c < budget && ack_q.size() < n; c++) step();
        chk({tag, "_nack"}, 32'(ack_q.size()), 32'(n));
    endtask

    task automatic wait_wr(input string tag, input int n, input int budget);
        for (int c = 0; c < budget && wr_byte_q.size() < n; c++) step();
        chk({tag, "_nwr_wait"}, 32'(wr_byte_q.size()), 32'(n));
    endtask

    logic [7:0] exp_b[$];

    initial begin
        // single message, three bytes, pitch and latency
        do_reset("rst0");
        set_req(0, 80'hAABBCC, 4'd3);
        i_req = 4'b0001;
        wait_done("t1", 1, 100);
        repeat (3) step();
        chk("t1_nwr", 32'(wr_byte_q.size()), 32'd3);
        chk("t1_nack_tot", 32'(ack_q.size()), 32'd1);
        if (wr_byte_q.size() == 3 && ack_q.size() == 1 && done_q.size() == 1) begin
            chk("t1_b0", 32'(wr_byte_q[0]), 32'hAA);
            chk("t1_b1", 32'(wr_byte_q[1]), 32'hBB);
            chk("t1_b2", 32'(wr_byte_q[2]), 32'hCC);
            chk("t1_pitch1", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'(GUARD + 2));
            chk("t1_pitch2", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 32'(GUARD + 2));
            chk("t1_lat", 32'(wr_cyc_q[0] - ack_cyc_q[0]), 32'd2);
            chk("t1_ackv", 32'(ack_q[0]), 32'h1);
            chk("t1_donev", 32'(done_q[0]), 32'h1);
            chk("t1_done_cyc", 32'(done_cyc_q[0] - wr_cyc_q[2]), 32'(GUARD));
        end
        chk("t1_busy_end", 32'(o_busy), 32'h0);

        // two simultaneous requesters after reset
        do_reset("rst2");
        set_req(0, 80'h11, 4'd1);
        set_req(2, 80'h33, 4'd1);
        i_req = 4'b0101;
        wait_done("t2", 2, 100);
        if (ack_q.size() == 2 && wr_byte_q.size() == 2 && done_q.size() == 2) begin
            chk("t2_gid0", 32'(ack_gid_q[0]), 32'd0);
            chk("t2_gid1", 32'(ack_gid_q[1]), 32'd2);
            chk("t2_ack1", 32'(ack_q[1]), 32'h4);
            chk("t2_b0", 32'(wr_byte_q[0]), 32'h11);
            chk("t2_b1", 32'(wr_byte_q[1]), 32'h33);
            chk("t2_done1", 32'(done_q[1]), 32'h4);
            chk("t2_gap", 32'(ack_cyc_q[1] - done_cyc_q[0]), 32'd2);
        end else begin
            chk("t2_counts", 32'(ack_q.size() + wr_byte_q.size()), 32'd4);
        end

        // all four requesting continuously
        do_reset("rst3");
        for (int i = 0; i < NREQ; i++) set_req(i, 80'(8'h40 + i), 4'd1);
        auto_clr = 1'b0;
        i_req = 4'hF;
        wait_acks("t3", 5, 200);
        i_req = '0;
        auto_clr = 1'b1;
        wait_done("t3", 5, 60);
        if (ack_q.size() == 5 && wr_byte_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t3_gid%0d", i), 32'(ack_gid_q[i]), 32'(i % 4));
                chk($sformatf("t3_b%0d", i), 32'(wr_byte_q[i]), 32'(8'h40 + (i % 4)));
            end
        end

        // transmitter stall before byte 2
        do_reset("rst4");
        set_req(0, 80'h010203, 4'd3);
        i_req = 4'b0001;
        wait_wr("t4", 1, 20);
        i_tx_rdy = 1'b0;
        repeat (20) step();
        chk("t4_stall_nwr", 32'(wr_byte_q.size()), 32'd1);
        i_tx_rdy = 1'b1;
        wait_done("t4", 1, 60);
        repeat (2) step();
        chk("t4_nwr", 32'(wr_byte_q.size()), 32'd3);
        if (wr_byte_q.size() == 3) begin
            chk("t4_b0", 32'(wr_byte_q[0]), 32'h01);
            chk("t4_b1", 32'(wr_byte_q[1]), 32'h02);
            chk("t4_b2", 32'(wr_byte_q[2]), 32'h03);
            chk("t4_resume", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd21);
        end

        // zero length, then over-length clamped to 10
        do_reset("rst5");
        set_req(0, 80'hDEAD, 4'd0);
        i_req = 4'b0001;
        wait_done("t5a", 1, 20);
        repeat (3) step();
        chk("t5a_nwr", 32'(wr_byte_q.size()), 32'd0);
        chk("t5a_nack", 32'(ack_q.size()), 32'd1);
        if (ack_q.size() == 1 && done_q.size() == 1) begin
            chk("t5a_same_cyc", 32'(done_cyc_q[0] - ack_cyc_q[0]), 32'd0);
            chk("t5a_donev", 32'(done_q[0]), 32'h1);
        end
        clear_logs();
        set_req(0, 80'h0102030405060708090A, 4'd15);
        i_req = 4'b0001;
        wait_done("t5b", 1, 150);
        repeat (3) step();
        chk("t5b_nwr", 32'(wr_byte_q.size()), 32'd10);
        if (wr_byte_q.size() == 10) begin
            for (int j = 0; j < 10; j++) begin
                chk($sformatf("t5b_b%0d", j), 32'(wr_byte_q[j]), 32'(j + 1));
            end
        end

        // reset in the middle of a 5-byte message
        do_reset("rst6");
        set_req(0, 80'h1122334455, 4'd5);
        i_req = 4'b0001;
        wait_wr("t6", 2, 40);
        repeat (2) step();
        i_rst = 1'b1;
        step();
        outs_idle("t6_mid");
        i_rst = 1'b0;
        repeat (10) step();
        chk("t6_no_done", 32'(done_q.size()), 32'd0);
        chk("t6_nwr_abort", 32'(wr_byte_q.size()), 32'd2);
        clear_logs();
        set_req(0, 80'hA1A2, 4'd2);
        set_req(1, 80'hB1, 4'd1);
        i_req = 4'b0011;
        wait_done("t6r", 2, 100);
        exp_b = '{8'hA1, 8'hA2, 8'hB1};
        if (ack_q.size() == 2 && wr_byte_q.size() == 3) begin
            chk("t6_gid0", 32'(ack_gid_q[0]), 32'd0);
            chk("t6_gid1", 32'(ack_gid_q[1]), 32'd1);
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("t6_b%0d", j), 32'(wr_byte_q[j]), 32'(exp_b[j]));
            end
        end else begin
            chk("t6_counts", 32'(ack_q.size() * 16 + wr_byte_q.size()), 32'h23);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_msg_arb.md
# uart_msg_arb

Shares the single UART byte transmitter among NREQ message requesters. Each requester offers a payload of up to 10 bytes; the block grants requesters round-robin, latches the winning payload and streams it MSB-byte-first as one-cycle byte writes to the transmitter. It sits between the test/monitor sources and the UART TX byte engine, replacing per-source packetizers.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- GUARD, 5, wait cycles after each byte write before sampling tx_rdy
- MAXB, 10, maximum bytes per message

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  NREQ  per-requester request level; hold until req_ack
- req_data  in  NREQ*80  payload; requester i uses bits [80*i+79:80*i], valid bytes right-aligned
- req_len  in  NREQ*4  byte count; requester i uses bits [4*i+3:4*i]
- req_ack  out  NREQ  one-cycle pulse: payload of that requester latched
- msg_done  out  NREQ  one-cycle pulse: last byte of that message accepted by transmitter
- grant_id  out  3  index of current/last granted requester
- busy  out  1  high from LOAD until return to IDLE
- uart_data  out  8  byte to transmitter
- uart_wr  out  1  one-cycle write strobe
- tx_rdy  in  1  transmitter idle, may accept a byte

## Operation
- Reset values: uart_data 8'h00, uart_wr 0, req_ack 0, msg_done 0, busy 0, grant_id 0; RR pointer = NREQ-1 so requester 0 wins first.
- States: IDLE, LOAD, WAITRDY, ISSUE, GUARD.
- IDLE: if any req, RR arbiter picks first set bit searching from pointer+1 (wrapping); register grant_id, go LOAD.
- LOAD: latch req_data/req_len of grant; pulse req_ack[grant]; update pointer = grant; byte index k=0; go WAITRDY.
- Length rule: len 0 -> ack, no bytes, msg_done pulses in the LOAD cycle, return to IDLE; len > MAXB clamped to MAXB.
- WAITRDY: stay while tx_rdy=0; when tx_rdy=1 go ISSUE.
- ISSUE: uart_wr=1, uart_data = payload[8*(len-k)-1 -: 8]; go GUARD.
- GUARD: counter GUARD cycles (tx_rdy ignored); then if k==last byte pulse msg_done[grant] and go IDLE, else k++ and go WAITRDY.
- Requests arriving during a message are queued by level only; no preemption.
- req deasserted before ack: not served; no state.
- Reset mid-message: message abandoned, no msg_done, outputs to reset values next edge.

## Timing
- req sampled in IDLE -> LOAD next edge -> req_ack in LOAD cycle (1-cycle latency from sampled req).
- With tx_rdy held 1: first uart_wr 3 cycles after req seen (IDLE, LOAD, WAITRDY, ISSUE); byte pitch = GUARD+2 cycles.
- msg_done asserted in the final GUARD cycle; IDLE next cycle; a pending request gets LOAD one cycle later (one idle gap minimum between messages).
- uart_data holds its value after ISSUE until next ISSUE.

## Configuration
- UART_ARB_CHKSUM_EN defined: after the last payload byte an extra byte = XOR of all sent payload bytes is issued through WAITRDY/ISSUE/GUARD; msg_done follows the checksum byte; len 0 sends checksum 8'h00 only.
- Undefined: payload bytes only, no checksum logic.

## Structure
- Package uart_arb_pkg: state encoding enum, MAXB, payload width 80, length width 4.
- Sub-module rr_arb: NREQ-wide request vector + pointer -> one-hot grant and index, purely combinational, reused by other shared-resource blocks.

## Test plan
- Single req0, len 3, data 80'h...AABBCC, tx_rdy=1 -> uart_wr bytes AA, BB, CC at pitch 7 cycles; req_ack[0] once; msg_done[0] once after CC.
- req0 and req2 asserted together after reset, len 1 each -> req0 served first, then req2; grant_id 0 then 2.
- All four requesting continuously -> grant order 0,1,2,3,0; no requester twice before others.
- tx_rdy held 0 for 20 cycles before byte 2 -> uart_wr stays 0 until tx_rdy rises; no byte lost or duplicated.
- req_len 0 and req_len 15 -> first: ack+msg_done, no uart_wr; second: exactly 10 bytes sent.
- rst pulsed during byte 2 of 5 -> all outputs reset next cycle, no msg_done; next request starts at byte 0 with requester 0 priority.
